// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, nop encoding and fetch controller states
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_t;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold and bubble-clear controls
module if_id_reg
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               clear,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [ADDR_W-1:0]  d_pc4,
    output logic [INSTR_W-1:0] q_instr,
    output logic [ADDR_W-1:0]  q_pc4,
    output logic               q_valid
);

    // Clear inserts a bubble and wins over hold; otherwise capture unless held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_instr <= NOP_INSTR;
            q_pc4   <= '0;
            q_valid <= 1'b0;
        end else if (clear) begin
            q_instr <= NOP_INSTR;
            q_pc4   <= '0;
            q_valid <= 1'b0;
        end else if (!hold) begin
            q_instr <= d_instr;
            q_pc4   <= d_pc4;
            q_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch stage: PC, redirect/stall handling, IF/ID
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] PC_LIMIT = 32'd48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_start,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc4,
    output logic               if_id_valid,
    output logic               halted,
    output logic [31:0]        fetch_count
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_plus4, target_al;
    logic              ifid_hold, ifid_clear, count_en;

    assign pc_plus4   = pc + 32'd4;
    assign target_al  = align_word(redirect_target);
    assign imem_addr  = pc;
    assign imem_start = (state != ST_IDLE);
    assign halted     = (state == ST_DONE);

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, next PC and IF/ID control; redirect beats stall beats limit beats advance.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        ifid_hold  = 1'b1;
        ifid_clear = 1'b0;
        count_en   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_nxt     = target_al;
                    ifid_clear = 1'b1;
                end else if (!stall) begin
                    if (pc >= PC_LIMIT) begin
                        ifid_clear = 1'b1;
                        state_nxt  = ST_DONE;
                    end else begin
                        ifid_hold = 1'b0;
                        pc_nxt    = pc_plus4;
                        count_en  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (redirect) begin
                    pc_nxt     = target_al;
                    ifid_clear = 1'b1;
                    if (target_al < PC_LIMIT) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Program counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

    // Count of instructions captured into IF/ID, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (count_en) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (ifid_hold),
        .clear   (ifid_clear),
        .d_instr (imem_instr),
        .d_pc4   (pc_plus4),
        .q_instr (if_id_instr),
        .q_pc4   (if_id_pc4),
        .q_valid (if_id_valid)
    );

endmodule
